atm_credential_entry: RTL

// Keypad front end that sits directly upstream of the ATM controller and its

---
 rtl/atm_credential_entry.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/atm_credential_entry.sv
// rtl/atm_credential_entry.sv - keypad credential entry, auth wait, try counting and lockout
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   key_valid/key_code       keypad key stream; key_ready accepts it
//   cred_valid/cred_ready    credential offer handshake (acc_number, pin)
//   auth_done/auth_ok        one-cycle authentication verdict
//   session_end              exit/abort request from the ATM controller
//   logged_in, locked        session and lockout status
//   entry_error              one-cycle pulse on malformed entry or failed auth
//   digit_count              digits held for the field being entered
module atm_credential_entry #(
    parameter int ACC_DIGITS   = 4,
    parameter int MAX_TRIES    = 3,
    parameter int LOCK_CYCLES  = 1024,
    parameter int IDLE_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        key_ready,
    output logic        cred_valid,
    input  logic        cred_ready,
    output logic [11:0] acc_number,
    output logic [3:0]  pin,
    input  logic        auth_done,
    input  logic        auth_ok,
    input  logic        session_end,
    output logic        logged_in,
    output logic        locked,
    output logic        entry_error,
    output logic [2:0]  digit_count
);

    localparam int LW = $clog2(LOCK_CYCLES);
    localparam int IW = $clog2(IDLE_TIMEOUT);

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_ENTER  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    typedef enum logic [2:0] {
        ACC_ENTRY, PIN_ENTRY, OFFER, WAIT_AUTH, SESSION, LOCKED
    } state_t;

    state_t        state_q, state_d;
    logic [13:0]   acc_q, acc_d;      // wide enough for acc*10+d up to 9999
    logic [3:0]    pin_q, pin_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [2:0]    tries_q, tries_d;
    logic [LW-1:0] lock_q, lock_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          err_d;
    logic          key_ready_q, cred_valid_q, logged_in_q, locked_q, err_q;

    logic key_acc, is_digit, in_entry, held;

    assign key_acc  = key_valid & key_ready_q;
    assign is_digit = (key_code <= 4'd9);
    assign in_entry = (state_q == ACC_ENTRY) || (state_q == PIN_ENTRY);
    // In PIN_ENTRY the account digits are always held, so the timer always runs there.
    assign held     = (state_q == PIN_ENTRY) || (cnt_q != 3'd0);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        pin_d   = pin_q;
        cnt_d   = cnt_q;
        tries_d = tries_q;
        lock_d  = lock_q;
        idle_d  = idle_q;
        err_d   = 1'b0;
        case (state_q)
            ACC_ENTRY, PIN_ENTRY: begin
                if (key_acc) begin
                    idle_d = '0;
                    if (is_digit) begin
                        if (state_q == ACC_ENTRY) begin
                            if (cnt_q < 3'(ACC_DIGITS)) begin
                                acc_d = acc_q * 14'd10 + {10'd0, key_code};
                                cnt_d = cnt_q + 3'd1;
                            end
                        end else if (cnt_q == 3'd0) begin
                            pin_d = key_code;
                            cnt_d = 3'd1;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        if (state_q == ACC_ENTRY) acc_d = '0;
                        else                      pin_d = '0;
                        cnt_d = '0;
                    end else if (key_code == KEY_ENTER) begin
                        if (state_q == ACC_ENTRY) begin
                            if (cnt_q == 3'(ACC_DIGITS) && acc_q <= 14'd4095) begin
                                state_d = PIN_ENTRY;
                            end else begin
                                err_d = 1'b1;
                                acc_d = '0;
                            end
                            cnt_d = '0;
                        end else if (cnt_q == 3'd1) begin
                            state_d = OFFER;
                            cnt_d   = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (key_code == KEY_CANCEL) begin
                        acc_d   = '0;
                        pin_d   = '0;
                        cnt_d   = '0;
                        state_d = ACC_ENTRY;
                    end
                end else if (held) begin
                    if (idle_q == IW'(IDLE_TIMEOUT - 1)) begin
                        acc_d   = '0;
                        pin_d   = '0;
                        cnt_d   = '0;
                        idle_d  = '0;
                        state_d = ACC_ENTRY;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            OFFER: begin
                if (session_end) begin
                    acc_d = '0; pin_d = '0; cnt_d = '0; idle_d = '0;
                    state_d = ACC_ENTRY;
                end else if (cred_valid_q && cred_ready) begin
                    state_d = WAIT_AUTH;
                end
            end
            WAIT_AUTH: begin
                // session_end takes priority so a simultaneous verdict is not counted.
                if (session_end) begin
                    acc_d = '0; pin_d = '0; cnt_d = '0; idle_d = '0;
                    state_d = ACC_ENTRY;
                end else if (auth_done) begin
                    if (auth_ok) begin
                        tries_d = '0;
                        state_d = SESSION;
                    end else begin
                        err_d   = 1'b1;
                        tries_d = tries_q + 3'd1;
                        acc_d = '0; pin_d = '0; cnt_d = '0; idle_d = '0;
                        state_d = (tries_q + 3'd1 == 3'(MAX_TRIES)) ? LOCKED : ACC_ENTRY;
                    end
                end
            end
            SESSION: begin
                if (session_end) begin
                    acc_d = '0; pin_d = '0; cnt_d = '0; idle_d = '0;
                    state_d = ACC_ENTRY;
                end
            end
            LOCKED: begin
                if (lock_q == LW'(LOCK_CYCLES - 1)) begin
                    lock_d  = '0;
                    tries_d = '0;
                    state_d = ACC_ENTRY;
                end else begin
                    lock_d = lock_q + 1'b1;
                end
            end
            default: state_d = ACC_ENTRY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ACC_ENTRY;
            acc_q        <= '0;
            pin_q        <= '0;
            cnt_q        <= '0;
            tries_q      <= '0;
            lock_q       <= '0;
            idle_q       <= '0;
            key_ready_q  <= 1'b1;
            cred_valid_q <= 1'b0;
            logged_in_q  <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            pin_q        <= pin_d;
            cnt_q        <= cnt_d;
            tries_q      <= tries_d;
            lock_q       <= lock_d;
            idle_q       <= idle_d;
            key_ready_q  <= (state_d == ACC_ENTRY) || (state_d == PIN_ENTRY);
            cred_valid_q <= (state_d == OFFER);
            logged_in_q  <= (state_d == SESSION);
            locked_q     <= (state_d == LOCKED);
            err_q        <= err_d;
        end
    end

    assign key_ready   = key_ready_q;
    assign cred_valid  = cred_valid_q;
    assign logged_in   = logged_in_q;
    assign locked      = locked_q;
    assign entry_error = err_q;
    assign acc_number  = acc_q[11:0];
    assign pin         = pin_q;
    assign digit_count = cnt_q;

endmodule
